// File: rtl/sonar_core.sv
`default_nettype none
// ============================================================================
// Module   : sonar_core
// Purpose  : sonar scan cycle - trigger/echo ranging in BCD centimetres,
//            7O2 UART report, 8-step servo sweep, 7-segment display
// Revision : 1.0
// ============================================================================
module sonar_core #(
    parameter int CYCLES_PER_CM  = 2941,
    parameter int TRIGGER_CYCLES = 500,
    parameter int ECHO_TIMEOUT   = 3_000_000,
    parameter int PWM_PERIOD     = 1_000_000,
    parameter int BAUD_DIV       = 434,
    parameter int PWM_BASE       = 50_000,
    parameter int PWM_STEP       = 7_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        echo,
    input  logic        display_mode,
    output logic        trigger,
    output logic        pwm,
    output logic        saida_serial,
    output logic        fim_posicao,
    output logic [11:0] medida,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        db_fim_transmissao,
    output logic        db_fim_posicao,
    output logic        db_saida_serial
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_TRIGGER     = 3'd1,
        S_ESPERA_ECHO = 3'd2,
        S_MEDE        = 3'd3,
        S_ARMAZENA    = 3'd4,
        S_TRANSMITE   = 3'd5,
        S_PROXIMA     = 3'd6
    } state_t;

    localparam logic [31:0] TRIG_LAST = 32'(TRIGGER_CYCLES - 1);
    localparam logic [31:0] TOUT_LAST = 32'(ECHO_TIMEOUT - 1);
    localparam logic [31:0] CM_FULL   = 32'(CYCLES_PER_CM);
    // Starting the divider half a centimetre in rounds the result to nearest.
    localparam logic [31:0] CM_OFFSET = 32'(CYCLES_PER_CM / 2);
    localparam logic [31:0] BAUD_LAST = 32'(BAUD_DIV - 1);
    localparam logic [31:0] PWM_LAST  = 32'(PWM_PERIOD - 1);

    state_t      state_q, state_d;
    logic        ligar_q, ligar_d;
    logic        ligar_prev_q, ligar_prev_d;
    logic        echo_q, echo_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] div_q, div_d;
    logic [11:0] cm_q, cm_d;
    logic [11:0] medida_q, medida_d;
    logic [2:0]  pos_q, pos_d;
    logic [31:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [2:0]  chr_q, chr_d;
    logic        saida_q, saida_d;
    logic        trigger_q, trigger_d;
    logic        fim_tx_q, fim_tx_d;
    logic        fim_pos_q, fim_pos_d;
    logic [31:0] pwm_cnt_q, pwm_cnt_d;
    logic [31:0] pwm_thr_q, pwm_thr_d;
    logic        pwm_q, pwm_d;

    logic [31:0] div_base;
    logic [31:0] div_inc;
    logic        cm_wrap;
    logic [11:0] angle_bcd;
    logic [6:0]  tx_char;
    logic [10:0] frame;

    function automatic logic [11:0] bcd_inc_sat(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        case (pos_q)
            3'd0:    angle_bcd = 12'h020;
            3'd1:    angle_bcd = 12'h040;
            3'd2:    angle_bcd = 12'h060;
            3'd3:    angle_bcd = 12'h080;
            3'd4:    angle_bcd = 12'h100;
            3'd5:    angle_bcd = 12'h120;
            3'd6:    angle_bcd = 12'h140;
            default: angle_bcd = 12'h160;
        endcase
    end

    // Message layout: "AAA,DDD#"; frame is start, 7 data LSB first, odd parity, 2 stops.
    always_comb begin
        case (chr_q)
            3'd0:    tx_char = {3'b011, angle_bcd[11:8]};
            3'd1:    tx_char = {3'b011, angle_bcd[7:4]};
            3'd2:    tx_char = {3'b011, angle_bcd[3:0]};
            3'd3:    tx_char = 7'h2C;
            3'd4:    tx_char = {3'b011, medida_q[11:8]};
            3'd5:    tx_char = {3'b011, medida_q[7:4]};
            3'd6:    tx_char = {3'b011, medida_q[3:0]};
            default: tx_char = 7'h23;
        endcase
        frame = {2'b11, ~^tx_char, tx_char, 1'b0};
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        div_d    = div_q;
        cm_d     = cm_q;
        medida_d = medida_q;
        pos_d    = pos_q;
        baud_d   = '0;
        bit_d    = '0;
        chr_d    = '0;
        fim_tx_d = 1'b0;
        div_base = (state_q == S_ESPERA_ECHO) ? CM_OFFSET : div_q;
        div_inc  = div_base + 32'd1;
        cm_wrap  = (div_inc == CM_FULL);

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (ligar_q && !ligar_prev_q) begin
                    state_d = S_TRIGGER;
                end
            end
            S_TRIGGER: begin
                cm_d = '0;
                if (timer_q == TRIG_LAST) begin
                    timer_d = '0;
                    state_d = S_ESPERA_ECHO;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_ESPERA_ECHO: begin
                if (echo_q) begin
                    // The cycle echo is first seen counts as the first echo clock.
                    state_d = S_MEDE;
                    div_d   = cm_wrap ? '0 : div_inc;
                    cm_d    = {11'd0, cm_wrap};
                end else if (timer_q == TOUT_LAST) begin
                    state_d = S_ARMAZENA;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_MEDE: begin
                if (echo_q) begin
                    div_d = cm_wrap ? '0 : div_inc;
                    if (cm_wrap) begin
                        cm_d = bcd_inc_sat(cm_q);
                    end
                end else begin
                    state_d = S_ARMAZENA;
                end
            end
            S_ARMAZENA: begin
                medida_d = cm_q;
                state_d  = S_TRANSMITE;
            end
            S_TRANSMITE: begin
                bit_d = bit_q;
                chr_d = chr_q;
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 4'd10) begin
                        bit_d = '0;
                        chr_d = chr_q + 3'd1;
                        if (chr_q == 3'd7) begin
                            fim_tx_d = 1'b1;
                            state_d  = S_PROXIMA;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 32'd1;
                end
            end
            S_PROXIMA: begin
                pos_d   = pos_q + 3'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ligar_d      = ligar;
        ligar_prev_d = ligar_q;
        echo_d       = echo;
        trigger_d    = (state_q == S_TRIGGER);
        fim_pos_d    = (state_q == S_PROXIMA);
        saida_d      = (state_q == S_TRANSMITE) ? frame[bit_q] : 1'b1;
        // The servo position only takes effect at a period boundary.
        pwm_cnt_d    = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 32'd1;
        pwm_thr_d    = (pwm_cnt_q == PWM_LAST)
                       ? 32'(PWM_BASE) + 32'(PWM_STEP) * {29'd0, pos_q}
                       : pwm_thr_q;
        pwm_d        = (pwm_cnt_q < pwm_thr_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ligar_q      <= 1'b0;
            ligar_prev_q <= 1'b0;
            echo_q       <= 1'b0;
            timer_q      <= '0;
            div_q        <= '0;
            cm_q         <= '0;
            medida_q     <= '0;
            pos_q        <= '0;
            baud_q       <= '0;
            bit_q        <= '0;
            chr_q        <= '0;
            saida_q      <= 1'b1;
            trigger_q    <= 1'b0;
            fim_tx_q     <= 1'b0;
            fim_pos_q    <= 1'b0;
            pwm_cnt_q    <= '0;
            pwm_thr_q    <= 32'(PWM_BASE);
            pwm_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ligar_q      <= ligar_d;
            ligar_prev_q <= ligar_prev_d;
            echo_q       <= echo_d;
            timer_q      <= timer_d;
            div_q        <= div_d;
            cm_q         <= cm_d;
            medida_q     <= medida_d;
            pos_q        <= pos_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            chr_q        <= chr_d;
            saida_q      <= saida_d;
            trigger_q    <= trigger_d;
            fim_tx_q     <= fim_tx_d;
            fim_pos_q    <= fim_pos_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pwm_thr_q    <= pwm_thr_d;
            pwm_q        <= pwm_d;
        end
    end

    always_comb begin
        if (display_mode) begin
            hex0 = seg7({1'b0, state_q});
            hex1 = seg7({1'b0, pos_q});
            hex2 = 7'h7F;
            hex3 = 7'h7F;
            hex4 = 7'h7F;
            hex5 = 7'h7F;
        end else begin
            hex0 = seg7(medida_q[3:0]);
            hex1 = seg7(medida_q[7:4]);
            hex2 = seg7(medida_q[11:8]);
            hex3 = seg7(angle_bcd[3:0]);
            hex4 = seg7(angle_bcd[7:4]);
            hex5 = seg7(angle_bcd[11:8]);
        end
    end

    assign trigger            = trigger_q;
    assign pwm                = pwm_q;
    assign saida_serial       = saida_q;
    assign fim_posicao        = fim_pos_q;
    assign medida             = medida_q;
    assign db_fim_transmissao = fim_tx_q;
    assign db_fim_posicao     = fim_pos_q;
    assign db_saida_serial    = saida_q;

endmodule
`default_nettype wire

// File: tb/tb_sonar_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonar_core
// Purpose  : directed scan cycles on a scaled-down sonar_core
// Revision : 1.0
// ============================================================================
module tb_sonar_core;

    localparam int CPC  = 5;
    localparam int TRIG = 4;
    localparam int TOUT = 50;
    localparam int PER  = 200;
    localparam int BAUD = 4;
    localparam int BASE = 20;
    localparam int STEP = 10;

    localparam logic [6:0] SEG0 = 7'h40, SEG1 = 7'h79, SEG2 = 7'h24;
    localparam logic [6:0] SEG4 = 7'h19, SEG9 = 7'h10, BLNK = 7'h7F;

    localparam int S_TRIG = 0, S_TX = 1, S_FTX = 2, S_FIM = 3, S_PWM = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        ligar;
    logic        echo;
    logic        display_mode;
    logic        trigger, pwm, saida_serial, fim_posicao;
    logic [11:0] medida;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        db_fim_transmissao, db_fim_posicao, db_saida_serial;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [11:0] last_med = 12'h000;
    int          pwm_hi;

    always #10 clock = ~clock;

    sonar_core #(
        .CYCLES_PER_CM (CPC),
        .TRIGGER_CYCLES(TRIG),
        .ECHO_TIMEOUT  (TOUT),
        .PWM_PERIOD    (PER),
        .BAUD_DIV      (BAUD),
        .PWM_BASE      (BASE),
        .PWM_STEP      (STEP)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ligar             (ligar),
        .echo              (echo),
        .display_mode      (display_mode),
        .trigger           (trigger),
        .pwm               (pwm),
        .saida_serial      (saida_serial),
        .fim_posicao       (fim_posicao),
        .medida            (medida),
        .hex0              (hex0),
        .hex1              (hex1),
        .hex2              (hex2),
        .hex3              (hex3),
        .hex4              (hex4),
        .hex5              (hex5),
        .db_fim_transmissao(db_fim_transmissao),
        .db_fim_posicao    (db_fim_posicao),
        .db_saida_serial   (db_saida_serial)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int s);
        case (s)
            S_TRIG:  return trigger;
            S_TX:    return saida_serial;
            S_FTX:   return db_fim_transmissao;
            S_FIM:   return fim_posicao;
            default: return pwm;
        endcase
    endfunction

    task automatic wait_level(input int s, input logic lvl, input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            if (sig_of(s) === lvl) break;
            @(negedge clock);
        end
        check(tag, 64'(sig_of(s)), 64'(lvl));
    endtask

    task automatic check_disp(input string tag, input logic [41:0] exp);
        check(tag, 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(exp));
    endtask

    task automatic rx_msg(output logic [63:0] msg, output logic ok);
        logic [10:0] fr;
        msg = '0;
        ok  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            wait_level(S_TX, 1'b0, 100, "rx_start");
            repeat (BAUD / 2) @(negedge clock);
            for (int b = 0; b < 11; b++) begin
                fr[b] = saida_serial;
                if (b < 10) repeat (BAUD) @(negedge clock);
            end
            if (fr[0] !== 1'b0 || fr[10:9] !== 2'b11 || ^fr[8:1] !== 1'b1) ok = 1'b0;
            msg = {msg[55:0], 1'b0, fr[7:1]};
        end
    endtask

    task automatic measure_pwm(output int hi);
        wait_level(S_PWM, 1'b0, 2 * PER, "pwm_low");
        wait_level(S_PWM, 1'b1, 2 * PER, "pwm_rise");
        wait_level(S_PWM, 1'b0, 2 * PER, "pwm_low");
        wait_level(S_PWM, 1'b1, 2 * PER, "pwm_rise");
        hi = 0;
        while (pwm === 1'b1 && hi < PER) begin
            hi++;
            @(negedge clock);
        end
    endtask

    // mode 0: decode message; 1: pulse ligar while busy; 2: reset during TX
    task automatic do_cycle(input int n_echo, input logic [11:0] exp_med,
                            input logic [63:0] exp_msg, input int mode);
        logic [63:0] msg;
        logic        ok;
        int          n;
        ligar = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("trig_early", 64'(trigger), 64'(0));
        @(negedge clock);
        check("trig_rise", 64'(trigger), 64'(1));
        n = 0;
        for (int i = 0; i < 50 && trigger === 1'b1; i++) begin
            n++;
            if (i == 1) ligar = 1'b0;
            @(negedge clock);
        end
        ligar = 1'b0;
        check("trig_width", 64'(n), 64'(TRIG));
        if (n_echo > 0) begin
            repeat (3) @(negedge clock);
            echo = 1'b1;
            repeat (n_echo) @(negedge clock);
            echo = 1'b0;
            @(negedge clock);
            @(negedge clock);
            check("medida_hold", 64'(medida), 64'(last_med));
            @(negedge clock);
            check("medida", 64'(medida), 64'(exp_med));
        end else begin
            repeat (TOUT - 5) @(negedge clock);
            check("no_early_timeout", 64'(saida_serial), 64'(1));
        end
        if (mode == 0) begin
            rx_msg(msg, ok);
            if (n_echo == 0) check("medida_timeout", 64'(medida), 64'(exp_med));
            check("msg", msg, exp_msg);
            check("frame_7o2", 64'(ok), 64'(1));
            wait_level(S_FTX, 1'b1, 10, "fim_tx");
            wait_level(S_FIM, 1'b1, 5, "fim_pos");
            check("db_fim_pos", 64'(db_fim_posicao), 64'(1));
            @(negedge clock);
            check("fim_pulse_end", 64'(fim_posicao), 64'(0));
            last_med = exp_med;
        end else if (mode == 1) begin
            repeat (20) @(negedge clock);
            ligar = 1'b1;
            repeat (3) @(negedge clock);
            ligar = 1'b0;
            wait_level(S_FIM, 1'b1, 8 * 11 * BAUD + 50, "fim_pos_busy");
            n = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clock);
                if (trigger === 1'b1) n++;
            end
            check("busy_ignored", 64'(n), 64'(0));
            last_med = exp_med;
        end else begin
            wait_level(S_TX, 1'b0, 20, "tx_start");
            check("db_saida", 64'(db_saida_serial), 64'(0));
            #3 reset = 1'b0;
            #1;
            check("rst_tx_high", 64'(saida_serial), 64'(1));
            check("rst_medida", 64'(medida), 64'(0));
            check("rst_pwm", 64'(pwm), 64'(0));
            check_disp("rst_disp", {SEG0, SEG2, SEG0, SEG0, SEG0, SEG0});
            @(negedge clock);
            reset = 1'b1;
            repeat (3) @(negedge clock);
            last_med = 12'h000;
        end
    endtask

    initial begin
        reset        = 1'b0;
        ligar        = 1'b0;
        echo         = 1'b0;
        display_mode = 1'b0;
        repeat (10) @(negedge clock);
        check("reset_trigger", 64'(trigger), 64'(0));
        check("reset_pwm", 64'(pwm), 64'(0));
        check("reset_tx", 64'(saida_serial), 64'(1));
        check("reset_pulses", 64'({fim_posicao, db_fim_transmissao, db_fim_posicao}), 64'(0));
        check("reset_medida", 64'(medida), 64'(0));
        check_disp("reset_disp", {SEG0, SEG2, SEG0, SEG0, SEG0, SEG0});
        reset = 1'b1;
        @(negedge clock);
        check("pwm_first", 64'(pwm), 64'(1));
        measure_pwm(pwm_hi);
        check("pwm_high_p0", 64'(pwm_hi), 64'(BASE));

        do_cycle(498, 12'h100, "020,100#", 0);
        check_disp("disp_case1", {SEG0, SEG4, SEG0, SEG1, SEG0, SEG0});
        do_cycle(375, 12'h075, "040,075#", 0);
        display_mode = 1'b1;
        #1;
        check_disp("disp_mode1", {BLNK, BLNK, BLNK, BLNK, SEG2, SEG0});
        display_mode = 1'b0;
        measure_pwm(pwm_hi);
        check("pwm_high_p2", 64'(pwm_hi), 64'(BASE + 2 * STEP));
        do_cycle(850, 12'h170, "060,170#", 0);
        do_cycle(0, 12'h000, "080,000#", 0);
        do_cycle(375, 12'h075, "000,000#", 1);
        do_cycle(497, 12'h099, "120,099#", 0);
        do_cycle(3, 12'h001, "140,001#", 0);
        do_cycle(5100, 12'h999, "160,999#", 0);
        check_disp("disp_sat_wrap", {SEG0, SEG2, SEG0, SEG9, SEG9, SEG9});
        display_mode = 1'b1;
        #1;
        check("wrap_p0", 64'(hex1), 64'(SEG0));
        display_mode = 1'b0;
        do_cycle(2, 12'h000, "020,000#", 0);
        do_cycle(3, 12'h001, "000,000#", 2);
        do_cycle(375, 12'h075, "020,075#", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
